// File: rtl/bound_flasher_pkg.sv
// bound_flasher_pkg: state encoding, sequence bounds and thermometer decode for the bound flasher
package bound_flasher_pkg;
  localparam int LED_W = 16;
  localparam logic [4:0] TOP    = 5'd16;
  localparam logic [4:0] MID_LO = 5'd5;
  localparam logic [4:0] MID_HI = 5'd11;
  localparam logic [4:0] LOW_HI = 5'd6;
  localparam logic [4:0] KICK_A = 5'd5;
  localparam logic [4:0] KICK_B = 5'd0;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1   = 3'd1,
    S2   = 3'd2,
    S3   = 3'd3,
    S4   = 3'd4,
    S5   = 3'd5,
    S6   = 3'd6
  } state_t;
  function automatic logic [LED_W-1:0] therm(input logic [4:0] n);
    logic [LED_W:0] t;
    t = ((LED_W+1)'(1) << n) - (LED_W+1)'(1);
    return t[LED_W-1:0];
  endfunction
endpackage

// File: rtl/bound_flasher_flick_catcher.sv
// flick_catcher: latches a possibly sub-cycle flick pulse asynchronously; cleared on a clock edge
module flick_catcher (
  input  logic clk,
  input  logic reset,
  input  logic flick,
  input  logic clr,
  output logic flag
);
  always_ff @(posedge clk or negedge reset or posedge flick)
    if (!reset) flag <= 1'b0;
    else if (flick) flag <= 1'b1;
    else if (clr) flag <= 1'b0;
endmodule

// File: rtl/bound_flasher.sv
// bound_flasher: 16-LED thermometer up/down light sequence with flick-driven kickback.
// Define BOUND_FLASHER_DBG_EN to expose registered dbg_state/dbg_count outputs.
module bound_flasher
  import bound_flasher_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             flick,
  output logic [LED_W-1:0] LED
`ifdef BOUND_FLASHER_DBG_EN
  ,
  output logic [2:0]       dbg_state,
  output logic [4:0]       dbg_count
`endif
);
  state_t state, state_nxt;
  logic [4:0] cnt, cnt_nxt, up, dn;
  logic flag, clr;
  flick_catcher u_catch (.clk(clk), .reset(reset), .flick(flick), .clr(clr), .flag(flag));
  assign up = (cnt == TOP) ? cnt : cnt + 5'd1;
  assign dn = (cnt == 5'd0) ? cnt : cnt - 5'd1;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt   <= 5'd0;
      LED   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      LED   <= therm(cnt_nxt);
    end
  always_comb begin
    state_nxt = IDLE;
    cnt_nxt   = 5'd0;
    case (state)
      IDLE: begin
        state_nxt = flag ? S1 : IDLE;
        cnt_nxt   = flag ? 5'd1 : 5'd0;
      end
      S1: begin
        cnt_nxt   = up;
        state_nxt = (up == TOP) ? S2 : S1;
      end
      S2: begin
        cnt_nxt   = dn;
        state_nxt = (dn == MID_LO) ? (flag ? S1 : S3) : S2;
      end
      S3: begin
        cnt_nxt   = up;
        state_nxt = (up == MID_HI) ? S4 : S3;
      end
      S4: begin
        cnt_nxt   = dn;
        state_nxt = flag && (dn == KICK_A || dn == KICK_B) ? S3 : (dn == KICK_B ? S5 : S4);
      end
      S5: begin
        cnt_nxt   = up;
        state_nxt = (up == LOW_HI) ? S6 : S5;
      end
      S6: begin
        cnt_nxt   = dn;
        state_nxt = (dn == 5'd0) ? IDLE : S6;
      end
      default: ;
    endcase
  end
  // S2/S4 hold a pending flick until the next kickback point; every other edge consumes or discards it
  always_comb begin
    clr = !((state == S2 && cnt_nxt != MID_LO) ||
            (state == S4 && cnt_nxt != KICK_A && cnt_nxt != KICK_B));
  end
`ifdef BOUND_FLASHER_DBG_EN
  assign dbg_state = state;
  assign dbg_count = cnt;
`endif
endmodule

// File: tb/tb_bound_flasher.sv
// tb_bound_flasher: directed sequences; expected LED per edge queued by stimulus, checked by a monitor
module tb_bound_flasher;
  logic clk = 1'b0;
  logic reset, flick;
  logic [15:0] LED;
  logic [15:0] q[$];
  int errors = 0;
  int checks = 0;
  int edge_no = 0;

  bound_flasher dut (.clk(clk), .reset(reset), .flick(flick), .LED(LED));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    edge_no++;
    if (q.size() != 0) begin
      logic [15:0] e;
      e = q.pop_front();
      checks++;
      if (LED !== e) begin
        errors++;
        $display("FAIL led edge %0d: got %h expected %h", edge_no, LED, e);
      end
    end
  end

  function automatic logic [15:0] th(input int n);
    return 16'((32'd1 << n) - 32'd1);
  endfunction

  task automatic step(input logic [15:0] e, input bit p);
    @(negedge clk);
    q.push_back(e);
    if (p) begin
      #1 flick = 1'b1;
      #2 flick = 1'b0;
    end
  endtask

  task automatic ramp(input int a, input int b, input int pn);
    int s;
    s = (b >= a) ? 1 : -1;
    for (int n = a; ; n += s) begin
      step(th(n), n == pn);
      if (n == b) break;
    end
  endtask

  task automatic idle(input int k);
    repeat (k) step(16'h0000, 1'b0);
  endtask

  task automatic direct(input string name, input logic [15:0] e);
    checks++;
    if (LED !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, LED, e);
    end
  endtask

  task automatic tail_from_s3();
    ramp(6, 11, -1);
    ramp(10, 0, -1);
    ramp(1, 6, -1);
    ramp(5, 0, -1);
  endtask

  initial begin
    reset = 1'b1;
    flick = 1'b0;
    #1 reset = 1'b0;
    #1 direct("reset_led", 16'h0000);
    #1 reset = 1'b1;
    idle(100);
    // nominal run, 56 edges then idle
    ramp(1, 16, 1);
    ramp(15, 5, -1);
    tail_from_s3();
    idle(3);
    // kickback in S2 at N=5
    ramp(1, 16, 1);
    ramp(15, 5, 8);
    ramp(6, 16, -1);
    ramp(15, 5, -1);
    tail_from_s3();
    idle(2);
    // kickback in S4 at N=5
    ramp(1, 16, 1);
    ramp(15, 5, -1);
    ramp(6, 11, -1);
    ramp(10, 5, 7);
    tail_from_s3();
    idle(2);
    // kickback in S4 at N=0
    ramp(1, 16, 1);
    ramp(15, 5, -1);
    ramp(6, 11, -1);
    ramp(10, 0, 3);
    ramp(1, 11, -1);
    ramp(10, 0, -1);
    ramp(1, 6, -1);
    ramp(5, 0, -1);
    idle(2);
    // flicks in S1 and S3 are discarded
    ramp(1, 3, 1);
    ramp(4, 16, 8);
    ramp(15, 5, -1);
    ramp(6, 11, 9);
    ramp(10, 0, -1);
    ramp(1, 6, -1);
    ramp(5, 0, -1);
    idle(2);
    // reset mid-S3 with flick asserted
    ramp(1, 16, 1);
    ramp(15, 5, -1);
    ramp(6, 8, -1);
    @(negedge clk);
    flick = 1'b1;
    #1 reset = 1'b0;
    #1 direct("reset_mid_led", 16'h0000);
    flick = 1'b0;
    q.push_back(16'h0000);
    @(negedge clk);
    q.push_back(16'h0000);
    #1 reset = 1'b1;
    idle(10);
    ramp(1, 16, 1);
    ramp(15, 5, -1);
    tail_from_s3();
    idle(2);
    @(posedge clk);
    #3;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
